// File: rtl/pwm_load_sched.sv
// pwm_load_sched: divides the core clock into the load clock clkZ, keeps
// per-channel shadow A/B limits, commits them atomically on a clkZ fall and
// sequences the shared count enable so it changes only on frame boundaries.
module pwm_load_sched #(
    parameter int NCH = 4,
    parameter int W   = 7,
    parameter int DIV = 200,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clkCore,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CHW-1:0]     cfg_ch,
    input  logic [W-1:0]       cfg_A,
    input  logic [W-1:0]       cfg_B,
    input  logic               commit,
    input  logic               run,
    output logic               clkZ,
    output logic               en,
    output logic [NCH*W-1:0]   A_val_bus,
    output logic [NCH*W-1:0]   B_val_bus,
    output logic               applied,
    output logic               cfg_err
);

    localparam int CW   = $clog2(DIV);
    localparam int HALF = DIV / 2;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            boundary;
    logic            pend;
    logic            cfgd;
    logic            cfgd_nxt;
    logic            wr_fire;
    logic [W-1:0]    shadow_a [NCH];
    logic [W-1:0]    shadow_b [NCH];

    // Divider successor; the boundary is the edge on which cnt becomes DIV/2.
    always_comb begin
        cnt_nxt = (cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1;
    end

    assign boundary  = (cnt_nxt == CW'(HALF));
    // Writes stay blocked through the applied cycle so the host sees the
    // commit land before it may touch the shadows again.
    assign cfg_ready = !(pend || applied);
    assign wr_fire   = cfg_valid && cfg_ready;
    // A commit landing on this boundary already counts for the run decision.
    assign cfgd_nxt  = cfgd || (boundary && pend);

    // Divider and registered load clock; clkZ is decoded from the next count
    // so it is a flop output and cannot glitch.
    always_ff @(posedge clkCore or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= CW'(HALF);
            clkZ <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values of the others.
            cnt  <= cnt_nxt;
            clkZ <= (cnt_nxt < CW'(HALF));
        end
    end

    // Host-facing shadow registers and the sticky out-of-range flag.
    always_ff @(posedge clkCore or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: shadows are reset explicitly because a commit before any
            // write must publish zeros, not power-up garbage.
            for (int k = 0; k < NCH; k++) begin
                shadow_a[k] <= '0;
                shadow_b[k] <= '0;
            end
            cfg_err <= 1'b0;
        end else if (wr_fire) begin
            for (int k = 0; k < NCH; k++) begin
                if (cfg_ch == CHW'(k)) begin
                    shadow_a[k] <= cfg_A;
                    shadow_b[k] <= cfg_B;
                end
            end
            if (32'(cfg_ch) >= 32'(NCH)) begin
                cfg_err <= 1'b1;
            end
        end
    end

    // Commit pending flag and atomic shadow-to-active transfer at a boundary.
    always_ff @(posedge clkCore or negedge reset_n) begin
        if (!reset_n) begin
            pend      <= 1'b0;
            applied   <= 1'b0;
            cfgd      <= 1'b0;
            A_val_bus <= '0;
            B_val_bus <= '0;
        end else begin
            cfgd <= cfgd_nxt;
            if (boundary && pend) begin
                for (int k = 0; k < NCH; k++) begin
                    A_val_bus[k*W +: W] <= shadow_a[k];
                    B_val_bus[k*W +: W] <= shadow_b[k];
                end
                pend    <= 1'b0;
                applied <= 1'b1;
            end else begin
                applied <= 1'b0;
                if (commit && !pend) begin
                    pend <= 1'b1;
                end
            end
        end
    end

    // Run/idle next state; decisions are taken only on boundary edges.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch
        // is inferred.
        state_nxt = state;
        if (boundary) begin
            case (state)
                S_IDLE:  if (run && cfgd_nxt) state_nxt = S_RUN;
                S_RUN:   if (!run)            state_nxt = S_IDLE;
                default:                      state_nxt = S_IDLE;
            endcase
        end
    end

    // State register; en is registered from the next state so it moves with
    // the clkZ fall.
    always_ff @(posedge clkCore or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            en    <= 1'b0;
        end else begin
            state <= state_nxt;
            en    <= (state_nxt == S_RUN);
        end
    end

endmodule

// File: tb/tb_pwm_load_sched.sv
// Directed bench for pwm_load_sched: a scoreboard queue holds the bus images
// expected from each commit and a monitor pops them on every applied pulse.
module tb_pwm_load_sched;

    localparam int NCH  = 5;
    localparam int W    = 7;
    localparam int DIV  = 200;
    localparam int HALF = DIV / 2;
    localparam int CHW  = 3;

    typedef struct packed {
        logic [NCH*W-1:0] a;
        logic [NCH*W-1:0] b;
    } exp_t;

    logic               clkCore = 1'b0;
    logic               reset_n = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [CHW-1:0]     cfg_ch = '0;
    logic [W-1:0]       cfg_A = '0;
    logic [W-1:0]       cfg_B = '0;
    logic               commit = 1'b0;
    logic               run = 1'b0;
    logic               clkZ;
    logic               en;
    logic [NCH*W-1:0]   A_val_bus;
    logic [NCH*W-1:0]   B_val_bus;
    logic               applied;
    logic               cfg_err;

    int   n_cmp = 0;
    int   n_err = 0;
    int   k;
    logic en_prev = 1'b0;
    exp_t sb [$];
    int   exp_a [NCH];
    int   exp_b [NCH];

    pwm_load_sched #(.NCH(NCH), .W(W), .DIV(DIV)) dut (
        .clkCore   (clkCore),
        .reset_n   (reset_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_A     (cfg_A),
        .cfg_B     (cfg_B),
        .commit    (commit),
        .run       (run),
        .clkZ      (clkZ),
        .en        (en),
        .A_val_bus (A_val_bus),
        .B_val_bus (B_val_bus),
        .applied   (applied),
        .cfg_err   (cfg_err)
    );

    always #5 clkCore = ~clkCore;

    // Core edges since the last reset release.
    always @(posedge clkCore or negedge reset_n) begin
        if (!reset_n) k <= 0;
        else          k <= k + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t pack_model();
        exp_t v;
        v = '0;
        for (int i = 0; i < NCH; i++) begin
            v.a[i*W +: W] = W'(exp_a[i]);
            v.b[i*W +: W] = W'(exp_b[i]);
        end
        return v;
    endfunction

    // Monitor: clkZ waveform model, en edges on boundaries, scoreboard pops.
    always @(negedge clkCore) begin
        if (!reset_n) begin
            en_prev = 1'b0;
        end else begin
            chk("clkZ_wave", clkZ, ((HALF + k) % DIV) < HALF);
            if (en !== en_prev) chk("en_edge_on_boundary", k % DIV, 0);
            en_prev = en;
            if (applied === 1'b1) begin
                chk("applied_expected", applied, sb.size() != 0);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("A_val_bus", A_val_bus, e.a);
                    chk("B_val_bus", B_val_bus, e.b);
                    chk("applied_on_boundary", k % DIV, 0);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clkCore);
    endtask

    task automatic goto_phase(input int ph);
        for (int i = 0; i < 2 * DIV && (k % DIV) != ph; i++) tick(1);
    endtask

    task automatic cfg_write(input int ch, input int a, input int b);
        cfg_valid = 1'b1;
        cfg_ch    = CHW'(ch);
        cfg_A     = W'(a);
        cfg_B     = W'(b);
        chk("cfg_ready_at_write", cfg_ready, 1);
        tick(1);
        cfg_valid = 1'b0;
        if (ch < NCH) begin
            exp_a[ch] = a;
            exp_b[ch] = b;
        end
    endtask

    // Pulses commit for one cycle; returns the edge index that samples it.
    task automatic do_commit(input bit push_exp, output int kc);
        commit = 1'b1;
        kc = k + 1;
        if (push_exp) sb.push_back(pack_model());
        tick(1);
        commit = 1'b0;
    endtask

    task automatic wait_applied(output int at_k, output int ready_hi, output int en_lo);
        at_k = -1;
        ready_hi = 0;
        en_lo = 0;
        for (int i = 0; i < DIV + 4; i++) begin
            tick(1);
            if (cfg_ready !== 1'b0) ready_hi++;
            if (en !== 1'b1) en_lo++;
            if (applied === 1'b1) begin
                at_k = k;
                break;
            end
        end
        chk("applied_arrives", at_k >= 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kc, at_k, ready_hi, en_lo, kr;
        for (int i = 0; i < NCH; i++) begin
            exp_a[i] = 0;
            exp_b[i] = 0;
        end

        // Reset state.
        tick(3);
        chk("rst_clkZ", clkZ, 0);
        chk("rst_en", en, 0);
        chk("rst_applied", applied, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_A", A_val_bus, 0);
        chk("rst_B", B_val_bus, 0);
        reset_n = 1'b1;

        // Free-running divider; the monitor checks clkZ every cycle.
        tick(300);
        chk("idle_en", en, 0);
        chk("idle_cfg_ready", cfg_ready, 1);

        // run without any commit must not start the generators.
        run = 1'b1;
        tick(3 * DIV);
        chk("run_uncfg_en", en, 0);

        // First commit: ch2 limits, en rises on the same boundary.
        goto_phase(30);
        cfg_write(2, 40, 10);
        chk("ready_before_commit", cfg_ready, 1);
        do_commit(1'b1, kc);
        chk("ready_after_commit", cfg_ready, 0);
        wait_applied(at_k, ready_hi, en_lo);
        chk("ready_low_until_applied", ready_hi, 0);
        chk("commit_latency", (at_k - kc >= 1) && (at_k - kc <= DIV), 1);
        chk("en_with_applied", en, 1);
        chk("ch2_A", A_val_bus[20:14], 40);
        chk("ch2_B", B_val_bus[20:14], 10);
        tick(1);
        chk("applied_one_cycle", applied, 0);
        chk("ready_after_applied", cfg_ready, 1);

        // Commit while running: en must not drop.
        goto_phase(60);
        cfg_write(0, 127, 0);
        do_commit(1'b1, kc);
        wait_applied(at_k, ready_hi, en_lo);
        chk("run_commit_en_low_cycles", en_lo, 0);
        tick(1);
        chk("en_after_run_commit", en, 1);

        // Stop mid-frame: en falls exactly at the next boundary.
        goto_phase(50);
        run = 1'b0;
        kr = k;
        at_k = -1;
        for (int i = 0; i < 2 * DIV; i++) begin
            tick(1);
            if (en === 1'b0) begin
                at_k = k;
                break;
            end
        end
        chk("stop_edge", at_k, (kr / DIV + 1) * DIV);

        // Out-of-range write is accepted and dropped, cfg_err sticks.
        cfg_write(5, 99, 55);
        chk("cfg_err_set", cfg_err, 1);
        // Commit sampled on a boundary edge lands one frame later.
        goto_phase(DIV - 1);
        do_commit(1'b1, kc);
        chk("boundary_commit_not_applied", applied, 0);
        chk("boundary_commit_pending", cfg_ready, 0);
        wait_applied(at_k, ready_hi, en_lo);
        chk("boundary_commit_lands", at_k, kc + DIV);
        chk("cfg_err_sticky", cfg_err, 1);

        // Restart, then reset mid-frame with a commit pending.
        run = 1'b1;
        at_k = -1;
        for (int i = 0; i < 2 * DIV; i++) begin
            tick(1);
            if (en === 1'b1) begin
                at_k = k;
                break;
            end
        end
        chk("restart_en", en, 1);
        goto_phase(10);
        cfg_write(1, 33, 44);
        do_commit(1'b0, kc);
        goto_phase(150);
        chk("pend_before_reset", cfg_ready, 0);
        chk("clkZ_high_before_reset", clkZ, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_clkZ", clkZ, 0);
        chk("async_en", en, 0);
        chk("async_applied", applied, 0);
        chk("async_cfg_err", cfg_err, 0);
        chk("async_cfg_ready", cfg_ready, 1);
        chk("async_A", A_val_bus, 0);
        chk("async_B", B_val_bus, 0);
        for (int i = 0; i < NCH; i++) begin
            exp_a[i] = 0;
            exp_b[i] = 0;
        end
        tick(2);
        reset_n = 1'b1;
        tick(3 * DIV);
        chk("post_reset_en", en, 0);
        chk("post_reset_A", A_val_bus, 0);
        chk("post_reset_B", B_val_bus, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
